// File: rtl/exu_redirect_ctrl_pkg.sv
// Shared types and constants for the execute-stage redirect controller.
//   redirect_state_e : IDLE / REDIRECT (handshake pending) / DRAIN (flush hold)
//   REDIRECT_SRC_*   : encoding of redirect_src
package exu_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    RDR_IDLE     = 2'd0,
    RDR_REDIRECT = 2'd1,
    RDR_DRAIN    = 2'd2
  } redirect_state_e;

  localparam logic REDIRECT_SRC_ALU  = 1'b0;
  localparam logic REDIRECT_SRC_TRAP = 1'b1;

endpackage

// File: rtl/exu_redirect_ctrl_perf_cnt_sat.sv
// perf_cnt_sat: saturating event counter.
//   clk, rst_n : clock, async active-low reset (clears count)
//   inc        : count one event this cycle
//   cnt        : current count, sticks at all-ones
module perf_cnt_sat #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/exu_redirect_ctrl.sv
// exu_redirect_ctrl: arbitrates ALU and trap redirects, drives a valid/ready
// redirect handshake to the IFU and holds flush for DRAIN_CYCLES afterwards.
//   clk, rst_n            : clock, async active-low reset
//   alu_pc_load/alu_pc_out: ALU redirect pulse and target
//   trap_req/trap_pc      : trap redirect pulse and vector (wins over ALU)
//   ifu_redirect_ready    : IFU accepts the pending redirect
//   ifu_redirect_valid/pc : pending redirect and its target (bit0 cleared)
//   redirect_src          : 0=ALU, 1=trap
//   flush, busy           : high whenever not idle
// Optional macro EXU_REDIRECT_PERF_EN adds exu_is_branch and three saturating
// perf counters (perf_branch_cnt, perf_alu_redirect_cnt, perf_trap_cnt).
module exu_redirect_ctrl
  import exu_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_pc_load,
  input  logic [XLEN-1:0] alu_pc_out,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ifu_redirect_ready,
`ifdef EXU_REDIRECT_PERF_EN
  input  logic              exu_is_branch,
  output logic [PERF_W-1:0] perf_branch_cnt,
  output logic [PERF_W-1:0] perf_alu_redirect_cnt,
  output logic [PERF_W-1:0] perf_trap_cnt,
`endif
  output logic            ifu_redirect_valid,
  output logic [XLEN-1:0] ifu_redirect_pc,
  output logic            redirect_src,
  output logic            flush,
  output logic            busy
);

  // At least one bit so the DRAIN_CYCLES==0 build still elaborates.
  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
  localparam logic [XLEN-1:0] BIT0_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  redirect_state_e  state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             hs;
  logic             alu_acc;

  assign hs      = (state_q == RDR_REDIRECT) && ifu_redirect_ready;
  // Only idle accepts ALU redirects; anything later is wrong-path.
  assign alu_acc = (state_q == RDR_IDLE) && alu_pc_load && !trap_req;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    src_d   = src_q;
    drain_d = drain_q;
    // A trap is captured in every state, even on the handshake cycle.
    if (trap_req) begin
      state_d = RDR_REDIRECT;
      tgt_d   = trap_pc & BIT0_CLR;
      src_d   = REDIRECT_SRC_TRAP;
    end else begin
      unique case (state_q)
        RDR_IDLE: begin
          if (alu_pc_load) begin
            state_d = RDR_REDIRECT;
            tgt_d   = alu_pc_out & BIT0_CLR;
            src_d   = REDIRECT_SRC_ALU;
          end
        end
        RDR_REDIRECT: begin
          if (hs) begin
            state_d = (DRAIN_CYCLES == 0) ? RDR_IDLE : RDR_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
        RDR_DRAIN: begin
          if (drain_q == '0) state_d = RDR_IDLE;
          else               drain_d = drain_q - 1'b1;
        end
        default: state_d = RDR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RDR_IDLE;
      tgt_q   <= '0;
      src_q   <= REDIRECT_SRC_ALU;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      src_q   <= src_d;
      drain_q <= drain_d;
    end
  end

  assign ifu_redirect_valid = (state_q == RDR_REDIRECT);
  assign ifu_redirect_pc    = tgt_q;
  assign redirect_src       = src_q;
  assign busy               = (state_q != RDR_IDLE);
  assign flush              = busy;

`ifdef EXU_REDIRECT_PERF_EN
  perf_cnt_sat #(.W(PERF_W)) u_cnt_br (
    .clk(clk), .rst_n(rst_n), .inc(exu_is_branch), .cnt(perf_branch_cnt));
  perf_cnt_sat #(.W(PERF_W)) u_cnt_alu (
    .clk(clk), .rst_n(rst_n), .inc(alu_acc), .cnt(perf_alu_redirect_cnt));
  perf_cnt_sat #(.W(PERF_W)) u_cnt_trap (
    .clk(clk), .rst_n(rst_n), .inc(trap_req), .cnt(perf_trap_cnt));
`else
  logic unused_alu_acc;
  assign unused_alu_acc = alu_acc;
`endif

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Directed bench for exu_redirect_ctrl: main instance (DRAIN_CYCLES=2) and a
// DRAIN_CYCLES=0 instance share stimulus; each section checks one of them.
module tb_exu_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_pc_load, trap_req, ifu_redirect_ready;
  logic [31:0] alu_pc_out, trap_pc;
  logic        vld, src, fl, bsy;
  logic [31:0] pc;
  logic        vld0, src0, fl0, bsy0;
  logic [31:0] pc0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

`ifdef EXU_REDIRECT_PERF_EN
  logic       exu_is_branch;
  logic [3:0] pbr, palu, ptrap;
  logic [3:0] pbr0, palu0, ptrap0;
`endif

  exu_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(2), .PERF_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_pc_load(alu_pc_load), .alu_pc_out(alu_pc_out),
    .trap_req(trap_req), .trap_pc(trap_pc),
    .ifu_redirect_ready(ifu_redirect_ready),
`ifdef EXU_REDIRECT_PERF_EN
    .exu_is_branch(exu_is_branch), .perf_branch_cnt(pbr),
    .perf_alu_redirect_cnt(palu), .perf_trap_cnt(ptrap),
`endif
    .ifu_redirect_valid(vld), .ifu_redirect_pc(pc),
    .redirect_src(src), .flush(fl), .busy(bsy));

  exu_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(0), .PERF_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .alu_pc_load(alu_pc_load), .alu_pc_out(alu_pc_out),
    .trap_req(trap_req), .trap_pc(trap_pc),
    .ifu_redirect_ready(ifu_redirect_ready),
`ifdef EXU_REDIRECT_PERF_EN
    .exu_is_branch(exu_is_branch), .perf_branch_cnt(pbr0),
    .perf_alu_redirect_cnt(palu0), .perf_trap_cnt(ptrap0),
`endif
    .ifu_redirect_valid(vld0), .ifu_redirect_pc(pc0),
    .redirect_src(src0), .flush(fl0), .busy(bsy0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_pc_load = 1'b0; trap_req = 1'b0; ifu_redirect_ready = 1'b0;
    alu_pc_out = '0; trap_pc = '0;
`ifdef EXU_REDIRECT_PERF_EN
    exu_is_branch = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    #3;
    chk("rst_valid", vld, 0);
    chk("rst_pc",    pc,  0);
    chk("rst_src",   src, 0);
    chk("rst_flush", fl,  0);
    chk("rst_busy",  bsy, 0);
    chk("rst0_busy", bsy0, 0);
    step();
    rst_n = 1'b1;
    step();

    // ALU redirect, bit0 cleared, flush for REDIRECT + 2 drain cycles
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_1235;
    step();
    alu_pc_load = 1'b0;
    chk("t1_valid", vld, 1);
    chk("t1_pc",    pc,  32'h0000_1234);
    chk("t1_src",   src, 0);
    chk("t1_flush", fl,  1);
    ifu_redirect_ready = 1'b1;
    step();
    ifu_redirect_ready = 1'b0;
    chk("t1_d1_valid", vld, 0);
    chk("t1_d1_flush", fl,  1);
    step();
    chk("t1_d2_flush", fl,  1);
    step();
    chk("t1_idle_flush", fl,  0);
    chk("t1_idle_busy",  bsy, 0);

    // simultaneous trap + ALU: trap wins
    trap_req = 1'b1; trap_pc = 32'h8000_0000;
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0100;
    step();
    trap_req = 1'b0; alu_pc_load = 1'b0;
    chk("t2_valid", vld, 1);
    chk("t2_pc",    pc,  32'h8000_0000);
    chk("t2_src",   src, 1);
    ifu_redirect_ready = 1'b1;
    step();
    ifu_redirect_ready = 1'b0;
    step(); step();
    chk("t2_idle", bsy, 0);

    // pending redirect: ALU ignored, trap overwrites next cycle
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0400;
    step();                                   // cycle 1 pending
    alu_pc_load = 1'b0;
    chk("t3_c1_pc", pc, 32'h0000_0400);
    step();                                   // cycle 2
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0500;
    step();                                   // cycle 3
    alu_pc_load = 1'b0;
    chk("t3_c3_pc",  pc,  32'h0000_0400);
    chk("t3_c3_src", src, 0);
    trap_req = 1'b1; trap_pc = 32'h0000_0200;
    step();                                   // cycle 4
    trap_req = 1'b0;
    chk("t3_c4_valid", vld, 1);
    chk("t3_c4_pc",    pc,  32'h0000_0200);
    chk("t3_c4_src",   src, 1);

    // trap on the handshake cycle: stays in REDIRECT with new target
    ifu_redirect_ready = 1'b1; trap_req = 1'b1; trap_pc = 32'h0000_0301;
    step();
    trap_req = 1'b0;
    chk("t4_valid", vld, 1);
    chk("t4_pc",    pc,  32'h0000_0300);
    step();                                   // accepted -> DRAIN
    ifu_redirect_ready = 1'b0;
    chk("t4_drain_valid", vld, 0);
    chk("t4_drain_flush", fl,  1);
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0900;
    step();                                   // ALU ignored in DRAIN
    alu_pc_load = 1'b0;
    chk("t4_alu_ign_valid", vld, 0);
    trap_req = 1'b1; trap_pc = 32'h0000_0700;
    step();                                   // trap from DRAIN
    trap_req = 1'b0;
    chk("t4_trap_valid", vld, 1);
    chk("t4_trap_pc",    pc,  32'h0000_0700);
    chk("t4_trap_src",   src, 1);

    // DRAIN_CYCLES=0 instance
    do_reset();
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0020;
    step();
    alu_pc_load = 1'b0;
    chk("z_valid", vld0, 1);
    chk("z_flush", fl0,  1);
    ifu_redirect_ready = 1'b1;
    step();
    ifu_redirect_ready = 1'b0;
    chk("z_flush_drop", fl0, 0);
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0040;
    step();
    alu_pc_load = 1'b0;
    chk("z_second_valid", vld0, 1);
    chk("z_second_pc",    pc0,  32'h0000_0040);

    // async reset mid-handshake
    do_reset();
    alu_pc_load = 1'b1; alu_pc_out = 32'h0000_0abc;
    step();
    alu_pc_load = 1'b0;
    chk("ar_pre_valid", vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", vld, 0);
    chk("ar_flush", fl,  0);
    chk("ar_busy",  bsy, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("ar_post_valid", vld, 0);
    chk("ar_post_busy",  bsy, 0);

`ifdef EXU_REDIRECT_PERF_EN
    do_reset();
    chk("p_rst_br", pbr, 0);
    for (int i = 0; i < 20; i++) begin
      exu_is_branch = 1'b1;
      step();
    end
    exu_is_branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_pc_load = 1'b1; alu_pc_out = 32'h0000_1000;
      step();
      alu_pc_load = 1'b0; ifu_redirect_ready = 1'b1;
      step();
      ifu_redirect_ready = 1'b0;
      step(); step();
    end
    chk("p_branch", pbr,   4'd15);
    chk("p_alu",    palu,  4'd3);
    chk("p_trap",   ptrap, 4'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
